// File: rtl/multi_digit_display_driver_pkg.sv
// Shared display types: FSM states, active-low seven-segment glyphs and sizing helpers.
package multi_digit_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays off in every glyph
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [15:0][7:0] SEG_GLYPHS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_GLYPHS[nib];
    endfunction

    // ceil(width*0.302)+1 digits; 0.302 bounds log10(2) so every width-bit value fits
    function automatic int bcd_digits(input int width);
        return (width * 302 + 999) / 1000 + 1;
    endfunction

endpackage

// File: rtl/multi_digit_display_driver_if.sv
// Value handshake between a data source (master) and the display driver (slave).
interface multi_digit_display_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             valueValid;
    logic             valueReady;
    logic             hexMode;

    modport master (
        output value,
        output valueValid,
        output hexMode,
        input  valueReady
    );

    modport slave (
        input  value,
        input  valueValid,
        input  hexMode,
        output valueReady
    );
endinterface

// File: rtl/multi_digit_display_driver_bin_to_bcd_serial.sv
// Serial double-dabble: one add-3 + shift per cycle, WIDTH cycles per conversion.
module bin_to_bcd_serial
    import multi_digit_display_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = bcd_digits(WIDTH)
) (
    input  logic                    cmosClock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]        r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic [4*BCD_DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge cmosClock) begin
        if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        end
    end

    // done marks the cycle whose closing edge performs the final shift
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/multi_digit_display_driver.sv
// Accepts a value over valid/ready, converts to hex or BCD digits and scans them onto a muxed 7-seg display.
module multi_digit_display_driver
    import multi_digit_display_driver_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                 cmosClock,
    input  logic                 reset,
    multi_digit_display_driver_if.slave bus,
    output logic                 overflow,
    output logic [DIGITS-1:0]    sevenSegmentEnable,
    output logic [7:0]           sevenSegmentData
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int DIG_W      = 4 * DIGITS;
    localparam int HEX_EXT_W  = WIDTH + DIG_W;
    localparam int DEC_EXT_W  = 4 * BCD_DIGITS + DIG_W;
    localparam int PRE_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_start;
    logic                    w_load;

    logic [WIDTH-1:0]        r_value;
    logic                    r_hex;
    logic [DIG_W-1:0]        r_digits;
    logic                    r_overflow;

    logic                    w_conv_busy;
    logic                    w_conv_done;
    logic [4*BCD_DIGITS-1:0] w_bcd;
    logic [HEX_EXT_W-1:0]    w_hex_ext;
    logic [DEC_EXT_W-1:0]    w_dec_ext;

    logic [PRE_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [7:0]              w_seg;
    logic [DIGITS-1:0]       w_en;
    logic [DIGITS-1:0]       r_en;
    logic [7:0]              r_seg;

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next = bus.hexMode ? LOAD : CONV;
            CONV:    if (w_conv_done || !w_conv_busy) w_next = LOAD;
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == IDLE);
        w_xfer  = bus.valueValid && w_ready;
        w_start = w_xfer && !bus.hexMode;
        w_load  = (r_state == LOAD);
    end

    assign bus.valueReady = w_ready;

    always_ff @(posedge cmosClock) begin
        if (w_xfer) begin
            r_value <= bus.value;
            r_hex   <= bus.hexMode;
        end
    end

    bin_to_bcd_serial #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .cmosClock (cmosClock),
        .reset     (reset),
        .i_start   (w_start),
        .i_bin     (r_value_src()),
        .o_busy    (w_conv_busy),
        .o_done    (w_conv_done),
        .o_bcd     (w_bcd)
    );

    // The converter samples the bus directly on the transfer edge so CONV starts shifting next cycle
    function automatic logic [WIDTH-1:0] r_value_src();
        return bus.value;
    endfunction

    // Zero-extended views: low digits go to the display, anything above them flags overflow
    assign w_hex_ext = {{DIG_W{1'b0}}, r_value};
    assign w_dec_ext = {{DIG_W{1'b0}}, w_bcd};

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            r_digits   <= '0;
            r_overflow <= 1'b0;
        end else if (w_load) begin
            if (r_hex) begin
                r_digits   <= w_hex_ext[DIG_W-1:0];
                r_overflow <= |w_hex_ext[HEX_EXT_W-1:DIG_W];
            end else begin
                r_digits   <= w_dec_ext[DIG_W-1:0];
                r_overflow <= |w_dec_ext[DEC_EXT_W-1:DIG_W];
            end
        end
    end

    assign w_wrap = (r_presc == PRE_W'(REFRESH_DIV - 1));

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_nib   = r_digits[4*r_idx +: 4];
        w_blank = (BLANK_ZEROS != 0) && (r_idx != '0) && ((r_digits >> (4*r_idx)) == '0);
        if (r_overflow) begin
            w_seg = SEG_DASH;
        end else if (w_blank) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = hex_to_seg(w_nib);
        end
        w_en = ~(DIGITS'(1) << r_idx);
    end

    // Enable and data load together at the wrap so a digit never shows its neighbour's glyph
    always_ff @(posedge cmosClock) begin
        if (reset) begin
            r_en  <= '1;
            r_seg <= SEG_BLANK;
        end else if (w_wrap) begin
            r_en  <= w_en;
            r_seg <= w_seg;
        end
    end

    assign overflow           = r_overflow;
    assign sevenSegmentEnable = r_en;
    assign sevenSegmentData   = r_seg;

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Randomised bench for the display driver: 8-bit and 16-bit instances against a digit-level model.
module tb_multi_digit_display_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int WS [2] = '{8, 16};
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [13:0] RESET_OBS = {1'b1, 1'b0, 4'hF, 8'hFF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] in_val [2];
    logic        in_vld [2];
    logic        in_hex [2];

    multi_digit_display_driver_if #(.WIDTH(8))  bus8 ();
    multi_digit_display_driver_if #(.WIDTH(16)) bus16 ();

    logic       ovf8, ovf16;
    logic [3:0] en8, en16;
    logic [7:0] seg8, seg16;
    logic [13:0] obs [2];

    assign bus8.value       = in_val[0][7:0];
    assign bus8.valueValid  = in_vld[0];
    assign bus8.hexMode     = in_hex[0];
    assign bus16.value      = in_val[1];
    assign bus16.valueValid = in_vld[1];
    assign bus16.hexMode    = in_hex[1];
    assign obs[0] = {bus8.valueReady, ovf8, en8, seg8};
    assign obs[1] = {bus16.valueReady, ovf16, en16, seg16};

    multi_digit_display_driver #(.DIGITS(ND), .WIDTH(8), .REFRESH_DIV(RD), .BLANK_ZEROS(1)) dut8 (
        .cmosClock(clk), .reset(rst), .bus(bus8),
        .overflow(ovf8), .sevenSegmentEnable(en8), .sevenSegmentData(seg8));

    multi_digit_display_driver #(.DIGITS(ND), .WIDTH(16), .REFRESH_DIV(RD), .BLANK_ZEROS(1)) dut16 (
        .cmosClock(clk), .reset(rst), .bus(bus16),
        .overflow(ovf16), .sevenSegmentEnable(en16), .sevenSegmentData(seg16));

    int total = 0;
    int bad   = 0;

    // Reference model: digit values from plain arithmetic, applied after the documented latency
    int         m_cd   [2];
    int         m_cyc  [2];
    int         m_dig  [2][ND];
    int         m_pdig [2][ND];
    bit         m_ovf  [2];
    bit         m_povf [2];
    logic [3:0] m_en   [2];
    logic [7:0] m_seg  [2];
    int         m_pos;

    function automatic logic [7:0] glyph_of(int k, int i);
        int hi;
        hi = 0;
        if (m_ovf[k]) return 8'hBF;
        for (int j = 0; j < ND; j++) if (m_dig[k][j] != 0) hi = j;
        if (i > hi) return 8'hFF;
        return GLYPH[m_dig[k][i]];
    endfunction

    task automatic model_accept(int k);
        longint v, p;
        v = longint'(in_val[k]) & ((longint'(1) << WS[k]) - 1);
        p = 1;
        for (int j = 0; j < ND; j++) begin
            if (in_hex[k]) m_pdig[k][j] = int'((v >> (4*j)) & 15);
            else           m_pdig[k][j] = int'((v / p) % 10);
            p = p * 10;
        end
        m_povf[k] = in_hex[k] ? (v >= (longint'(1) << (4*ND))) : (v >= p);
        m_cd[k]   = in_hex[k] ? 1 : WS[k] + 1;
    endtask

    function automatic logic [13:0] exp_of(int k);
        return {(m_cd[k] == 0), m_ovf[k], m_en[k], m_seg[k]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cd[k] = 0; m_cyc[k] = 0; m_ovf[k] = 1'b0;
                m_en[k] = 4'hF; m_seg[k] = 8'hFF;
                for (int j = 0; j < ND; j++) m_dig[k][j] = 0;
            end else begin
                m_cyc[k]++;
                if (m_cyc[k] % RD == 0) begin
                    m_pos    = (m_cyc[k] / RD - 1) % ND;
                    m_en[k]  = ~(4'b0001 << m_pos);
                    m_seg[k] = glyph_of(k, m_pos);
                end
                if (m_cd[k] > 0) begin
                    m_cd[k]--;
                    if (m_cd[k] == 0) begin
                        for (int j = 0; j < ND; j++) m_dig[k][j] = m_pdig[k][j];
                        m_ovf[k] = m_povf[k];
                    end
                end else if (in_vld[k]) begin
                    model_accept(k);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== RESET_OBS) begin
                bad++; $display("FAIL reset_state dut%0d: got %h want %h", k, obs[k], RESET_OBS);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL reset_scan dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            if (c == 3) begin
                total++;
                if (en8 !== 4'hF) begin bad++; $display("FAIL first_wrap_early: got %h want F", en8); end
            end
            if (c == 4) begin
                total++;
                if ({en8, seg8} !== {4'hE, 8'hC0}) begin
                    bad++; $display("FAIL first_wrap: got %h/%h want E/C0", en8, seg8);
                end
            end
            if (c > 4 && en8 !== 4'hE) begin
                total++;
                if (seg8 !== 8'hFF) begin bad++; $display("FAIL zero_blank en=%h: got %h want FF", en8, seg8); end
            end
        end
    endtask

    task automatic test_hex_a5();
        in_val[0] = 16'h00A5; in_hex[0] = 1'b1; in_vld[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL hex_a5 dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            if (c == 1) begin
                in_vld[0] = 1'b0;
                total++;
                if (bus8.valueReady !== 1'b0) begin bad++; $display("FAIL hex_busy: got 1 want 0"); end
            end
            if (c == 2) begin
                total++;
                if (bus8.valueReady !== 1'b1) begin bad++; $display("FAIL hex_ready: got 0 want 1"); end
            end
            if (c >= 20) begin
                total++;
                if ((en8 == 4'hD && seg8 !== 8'h88) || (en8 == 4'hE && seg8 !== 8'h92) ||
                    ((en8 == 4'hB || en8 == 4'h7) && seg8 !== 8'hFF)) begin
                    bad++; $display("FAIL hex_a5_glyph en=%h: got %h", en8, seg8);
                end
            end
        end
    endtask

    task automatic test_dec_255();
        int low;
        low = 0;
        in_val[0] = 16'd255; in_hex[0] = 1'b0; in_vld[0] = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL dec_255 dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            if (c == 1) in_vld[0] = 1'b0;
            if (c <= 20 && bus8.valueReady !== 1'b1) low++;
            if (c >= 30) begin
                total++;
                if ((en8 == 4'h7 && seg8 !== 8'hFF) || (en8 == 4'hB && seg8 !== 8'hA4) ||
                    (en8 == 4'hD && seg8 !== 8'h92) || (en8 == 4'hE && seg8 !== 8'h92)) begin
                    bad++; $display("FAIL dec_255_glyph en=%h: got %h", en8, seg8);
                end
            end
        end
        total++;
        if (low != 9) begin bad++; $display("FAIL dec_latency: got %0d busy cycles want 9", low); end
    endtask

    task automatic test_overflow16();
        for (int pass = 0; pass < 2; pass++) begin
            in_val[1] = (pass == 0) ? 16'd10000 : 16'd9999;
            in_hex[1] = 1'b0; in_vld[1] = 1'b1;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (obs[k] !== exp_of(k)) begin
                        bad++; $display("FAIL ovf16 dut%0d p%0d c%0d: got %h want %h", k, pass, c, obs[k], exp_of(k));
                    end
                end
                if (c == 1) in_vld[1] = 1'b0;
                if (c >= 18) begin
                    total++;
                    if (ovf16 !== (pass == 0)) begin
                        bad++; $display("FAIL ovf16_flag p%0d: got %b want %b", pass, ovf16, pass == 0);
                    end
                end
                if (c >= 40) begin
                    total++;
                    if (seg16 !== ((pass == 0) ? 8'hBF : 8'h90)) begin
                        bad++; $display("FAIL ovf16_glyph p%0d en=%h: got %h", pass, en16, seg16);
                    end
                end
            end
        end
    endtask

    task automatic test_hold_valid();
        in_val[0] = 16'd200; in_hex[0] = 1'b0; in_vld[0] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL hold_valid dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            if (c == 10 || c == 11) begin
                total++;
                if (bus8.valueReady !== (c == 10)) begin
                    bad++; $display("FAIL hold_ready c%0d: got %b want %b", c, bus8.valueReady, c == 10);
                end
            end
            if (c <= 10) in_val[0] = 16'($urandom_range(0, 199));
            if (c == 11) in_vld[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        in_val[0] = 16'd123; in_hex[0] = 1'b0; in_vld[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL reset_mid dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            if (c == 1) in_vld[0] = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                rst = 1'b0;
                total++;
                if (obs[0] !== RESET_OBS) begin
                    bad++; $display("FAIL reset_mid_state: got %h want %h", obs[0], RESET_OBS);
                end
            end
            if (c > 4) begin
                total++;
                if (seg8 !== 8'hFF && seg8 !== 8'hC0) begin
                    bad++; $display("FAIL abandoned_value en=%h: got %h", en8, seg8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_of(k)) begin
                    bad++; $display("FAIL back_to_back dut%0d c%0d: got %h want %h", k, c, obs[k], exp_of(k));
                end
            end
            for (int k = 0; k < 2; k++) begin
                in_vld[k] = (c <= 70);
                in_val[k] = 16'($urandom);
                in_hex[k] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_random();
        int k, hold, len;
        for (int t = 0; t < 60; t++) begin
            k = int'($urandom_range(0, 1));
            in_hex[k] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) in_val[k] = 16'($urandom_range(0, 9999));
            else                           in_val[k] = 16'($urandom);
            in_vld[k] = 1'b1;
            hold = int'($urandom_range(1, 3));
            len  = 20 + int'($urandom_range(0, 12));
            for (int c = 1; c <= len; c++) begin
                @(negedge clk);
                for (int j = 0; j < 2; j++) begin
                    total++;
                    if (obs[j] !== exp_of(j)) begin
                        bad++; $display("FAIL random t%0d dut%0d c%0d: got %h want %h", t, j, c, obs[j], exp_of(j));
                    end
                end
                if (c == hold) in_vld[k] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_val[k] = '0; in_vld[k] = 1'b0; in_hex[k] = 1'b0;
        end
        test_reset();
        test_hex_a5();
        test_dec_255();
        test_overflow16();
        test_hold_valid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
